serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_pkg.sv | 7 +
 rtl/serial_fa_slice.sv | 11 +
 rtl/serial_add_seq.sv | 74 +++++++
 tb/tb_serial_add_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and counter sizing for the bit-serial adder
package serial_add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction
endpackage

// File: rtl/serial_fa_slice.sv
// serial_fa_slice: single-bit full adder shared across all bit positions
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: LSB-first bit-serial add/subtract with valid/ready handshakes
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout, r_ovf;
    logic             w_s, w_co, w_last, w_load;
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign w_load = r_state == IDLE && in_valid;
    serial_fa_slice u_slice (.a(r_a[0]), .b(r_b[0]), .ci(r_carry), .s(w_s), .co(w_co));
    always_comb begin
        w_next = r_state;
        w_next = w_load                        ? RUN  :
                 (r_state == RUN  && w_last)    ? DONE :
                 (r_state == DONE && out_ready) ? IDLE : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // Subtraction is a + ~b + 1, so the carry register doubles as the +1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_co;
            r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= r_carry ^ w_co;
            end
        end
    end
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed and randomized checks against an arithmetic reference model
module tb_serial_add_seq;
    localparam int W = 8;
    typedef struct packed {logic [7:0] s; logic c; logic v;} res_t;
    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0, sum;
    logic       in_ready, out_valid, cout, ovf, busy;
    int         checks = 0, errors = 0, lat = 0;
    bit         mon_en = 1'b0;
    res_t       q[$];
    res_t       r;
    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s);
        int ux = int'(x), uy = int'(y), sx = int'($signed(x)), sy = int'($signed(y)), u, sr;
        res_t m;
        u    = s ? ux - uy : ux + uy + int'(ci);
        sr   = s ? sx - sy : sx + sy + int'(ci);
        m.s  = 8'(u);
        m.c  = s ? (ux >= uy) : (u > 255);
        m.v  = (sr > 127) || (sr < -128);
        return m;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0) lat++;
            chk("mon_in_ready", 64'(in_ready), 64'(q.size() == 0));
            chk("mon_busy", 64'(busy), 64'(q.size() != 0));
            chk("mon_out_valid", 64'(out_valid), 64'(q.size() > 0 && lat >= W + 1));
            if (out_valid && q.size() > 0) chk("mon_result", 64'({sum, cout, ovf}), 64'(q[0]));
            if (rst) q.delete();
            else begin
                if (in_valid && in_ready) begin
                    q.push_back(model(a, b, cin, sub));
                    lat = 0;
                end
                if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            end
        end
    end
    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xc, input logic xs);
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask
    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin out_ready = 1'($urandom); @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        if (!out_valid) chk("valid_timeout", 64'(out_valid), 64'd1);
    endtask
    task automatic get(input int hold, output res_t res);
        wait_valid();
        repeat (hold) begin @(posedge clk); #1; end
        res = {sum, cout, ovf};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    initial begin
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_outputs", 64'({sum, cout, ovf}), 64'd0);
        chk("model_ff_01", 64'(model(8'hFF, 8'h01, 1'b0, 1'b0)), 64'({8'h00, 1'b1, 1'b0}));
        chk("model_7f_01", 64'(model(8'h7F, 8'h01, 1'b0, 1'b0)), 64'({8'h80, 1'b0, 1'b1}));
        chk("model_05_07_sub", 64'(model(8'h05, 8'h07, 1'b1, 1'b1)), 64'({8'hFE, 1'b0, 1'b0}));
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        repeat (W - 1) begin @(posedge clk); #1; end
        chk("latency_before", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("latency_at", 64'(out_valid), 64'd1);
        get(0, r);
        chk("ff_plus_01", 64'(r), 64'({8'h00, 1'b1, 1'b0}));
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        get(1, r);
        chk("7f_plus_01", 64'(r), 64'({8'h80, 1'b0, 1'b1}));
        send(8'h05, 8'h07, 1'b1, 1'b1);
        get(2, r);
        chk("05_minus_07", 64'(r), 64'({8'hFE, 1'b0, 1'b0}));
        send(8'h3C, 8'h5A, 1'b1, 1'b0);
        @(posedge clk); #1;
        a = 8'h01; b = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_stable", 64'({sum, cout, ovf}), 64'({8'h97, 1'b0, 1'b1}));
            in_valid = (i == 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_hs", 64'(in_ready), 64'd1);
        send(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_run_rst_ready", 64'(in_ready), 64'd1);
        repeat (12) begin @(posedge clk); #1; end
        chk("mid_run_rst_no_valid", 64'(out_valid), 64'd0);
        send(8'h12, 8'h34, 1'b0, 1'b0);
        get(0, r);
        chk("12_plus_34", 64'(r), 64'({8'h46, 1'b0, 1'b0}));
        send(8'h80, 8'h80, 1'b0, 1'b0);
        wait_valid();
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        chk("done_rst_valid", 64'(out_valid), 64'd0);
        chk("done_rst_outputs", 64'({sum, cout, ovf}), 64'd0);
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] xa, xb;
            logic       xc, xs;
            xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom); xs = 1'($urandom);
            send(xa, xb, xc, xs);
            get(int'($urandom_range(0, 3)), r);
            chk("random", 64'(r), 64'(model(xa, xb, xc, xs)));
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
